// File: rtl/inst_encoder_if.sv
// Handshake bundle for inst_encoder: decoded-field input stream and encoded-word output stream.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the input side and out_valid/out_ready on the output side.
// Ports (modports):
//   slave  - the encoder: consumes in_*, produces in_ready and out_*, consumes out_ready.
//   master - the producer/sink pair driving the encoder (program loader, bench).
interface inst_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err
  );
endinterface

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: packs decoded fields into instruction words with range-checked immediates.
// Latency: 1 cycle, single output register, full throughput (reload on simultaneous in/out handshake).
// Backpressure: in_ready = !out_valid || out_ready while loading; outputs hold while stalled.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   start        - begin a load session from IDLE/DONE (address and err_cnt cleared)
//   bus          - inst_encoder_if.slave: field input stream and encoded word/address output stream
//   err_cnt      - saturating count of unencodable words in the current session
//   done         - session complete (last word has left the output register)
module inst_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  inst_encoder_if.slave bus,
  output logic [7:0]    err_cnt,
  output logic          done
);

  localparam logic [31:0]       NOP       = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_SHIFT = 3'd2;
  localparam logic [2:0] FMT_S     = 3'd3;
  localparam logic [2:0] FMT_B     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_U     = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q,     state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q,  out_inst_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_err_q,   out_err_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [7:0]        err_cnt_q,   err_cnt_d;
  logic              done_q,      done_d;

  logic        in_hs;
  logic        out_hs;
  logic        legal;
  logic [31:0] enc;
  logic [31:0] imm;

  assign imm = bus.in_imm;

  // Ready depends combinationally on out_ready so a stalled-then-released
  // register can reload in the same cycle it drains.
  assign bus.in_ready = (state_q == S_LOAD) && (!out_valid_q || bus.out_ready);
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign out_hs       = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;
  assign err_cnt       = err_cnt_q;
  assign done          = done_q;

  // Field packing and immediate range check. "All equal" on the upper bits
  // means the value fits the sign-extended immediate of that format.
  always_comb begin
    enc   = NOP;
    legal = 1'b1;
    case (bus.in_fmt)
      FMT_R: begin
        enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      end
      FMT_I: begin
        enc   = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        legal = (&imm[31:11]) || !(|imm[31:11]);
      end
      FMT_SHIFT: begin
        enc   = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        legal = !(|imm[31:5]);
      end
      FMT_S: begin
        enc   = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
        legal = (&imm[31:11]) || !(|imm[31:11]);
      end
      FMT_B: begin
        enc   = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                 imm[4:1], imm[11], bus.in_opcode};
        legal = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
      end
      FMT_J: begin
        enc   = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        legal = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
      end
      FMT_U: begin
        enc   = {imm[31:12], bus.in_rd, bus.in_opcode};
        legal = !(|imm[11:0]);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    if (!legal) begin
      enc = NOP;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    next_addr_d = next_addr_q;
    err_cnt_d   = err_cnt_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          next_addr_d = '0;
          err_cnt_d   = '0;
          done_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_hs && bus.in_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last word is sitting in the output register; leave once it is taken.
        if (out_hs) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (out_hs) begin
      out_valid_d = 1'b0;
    end

    // An input handshake wins over the drain above, giving back-to-back words.
    // The address slot is taken at load time, so an error word still uses one.
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc;
      out_addr_d  = next_addr_q;
      out_err_d   = !legal;
      next_addr_d = (next_addr_q == LAST_ADDR) ? '0 : next_addr_q + ADDR_W'(1);
      if (!legal && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      next_addr_q <= '0;
      err_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      next_addr_q <= next_addr_d;
      err_cnt_q   <= err_cnt_d;
      done_q      <= done_d;
    end
  end

endmodule
